// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester and byte-transmitter handshake bundle for uart_tx_scheduler
interface uart_tx_scheduler_if;
    logic [1:0]  req_valid_in;
    logic [16:0] req0_data_in;
    logic [16:0] req1_data_in;
    logic [1:0]  req_ready_out;
    logic [7:0]  tx_byte_out;
    logic        tx_valid_out;
    logic        tx_ready_in;
    logic        grant_id_out;
    logic        busy_out;

    modport master (
        output req_valid_in, req0_data_in, req1_data_in, tx_ready_in,
        input  req_ready_out, tx_byte_out, tx_valid_out, grant_id_out, busy_out
    );

    modport slave (
        input  req_valid_in, req0_data_in, req1_data_in, tx_ready_in,
        output req_ready_out, tx_byte_out, tx_valid_out, grant_id_out, busy_out
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - two-requester round-robin scheduler framing 17-bit words into 3 tagged bytes
module uart_tx_scheduler #(
    parameter int GAP_CYCLES = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    uart_tx_scheduler_if.slave bus
);
    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, SEND_B1, SEND_B2, SEND_B3, GAP} state_t;

    state_t          r_state;
    logic [16:0]     r_word;
    logic            r_last_grant;
    logic [CW-1:0]   r_gap_cnt;
    logic [7:0]      r_tx_byte;
    logic            r_tx_valid;
    logic            r_grant_id;
    logic            r_busy;

    logic            w_grant;
    logic            w_take;
    logic [16:0]     w_sel_data;

    // On contention the requester not served last wins; a lone requester wins outright.
    always_comb begin
        if (bus.req_valid_in == 2'b11) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = bus.req_valid_in[1];
        end
    end

    assign w_take     = rst_n_in && (r_state == IDLE) && (|bus.req_valid_in);
    assign w_sel_data = w_grant ? bus.req1_data_in : bus.req0_data_in;

    assign bus.req_ready_out = w_take ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.tx_byte_out   = r_tx_byte;
    assign bus.tx_valid_out  = r_tx_valid;
    assign bus.grant_id_out  = r_grant_id;
    assign bus.busy_out      = r_busy;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_last_grant <= 1'b1;
            r_gap_cnt    <= '0;
            r_tx_byte    <= '0;
            r_tx_valid   <= 1'b0;
            r_grant_id   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|bus.req_valid_in) begin
                        r_word       <= w_sel_data;
                        r_last_grant <= w_grant;
                        r_grant_id   <= w_grant;
                        r_tx_byte    <= {2'b00, w_sel_data[5:0]};
                        r_tx_valid   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= SEND_B1;
                    end
                end
                SEND_B1: begin
                    if (bus.tx_ready_in) begin
                        r_tx_byte <= {2'b01, r_word[11:6]};
                        r_state   <= SEND_B2;
                    end
                end
                SEND_B2: begin
                    if (bus.tx_ready_in) begin
                        r_tx_byte <= {3'b100, r_word[16:12]};
                        r_state   <= SEND_B3;
                    end
                end
                SEND_B3: begin
                    if (bus.tx_ready_in) begin
                        r_tx_byte  <= '0;
                        r_tx_valid <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            r_gap_cnt <= GAP_LOAD;
                            r_state   <= GAP;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    // Counter starts at GAP_CYCLES-1, so leaving after it reads 0 spends exactly GAP_CYCLES cycles here.
                    if (r_gap_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_scheduler_if ifa ();
    uart_tx_scheduler_if ifb ();

    uart_tx_scheduler #(.GAP_CYCLES(4)) dut_a (.clk_in(clk), .rst_n_in(rst_n), .bus(ifa.slave));
    uart_tx_scheduler #(.GAP_CYCLES(0)) dut_b (.clk_in(clk), .rst_n_in(rst_n), .bus(ifb.slave));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int viol     = 0;
    int a_ready_cycles = 0;

    logic [7:0] qa_b[$];
    logic [7:0] qb_b[$];
    int         qa_bc[$];
    int         qb_bc[$];
    logic       qa_g[$];
    logic       qb_g[$];
    int         qa_gc[$];
    int         qb_gc[$];

    always @(negedge clk) begin
        if (ifa.tx_valid_out && ifa.tx_ready_in) begin
            qa_b.push_back(ifa.tx_byte_out);
            qa_bc.push_back(cyc);
        end
        if (ifb.tx_valid_out && ifb.tx_ready_in) begin
            qb_b.push_back(ifb.tx_byte_out);
            qb_bc.push_back(cyc);
        end
        if (|(ifa.req_ready_out & ifa.req_valid_in)) begin
            qa_g.push_back(ifa.req_ready_out[1]);
            qa_gc.push_back(cyc);
        end
        if (|(ifb.req_ready_out & ifb.req_valid_in)) begin
            qb_g.push_back(ifb.req_ready_out[1]);
            qb_gc.push_back(cyc);
        end
        if (ifa.req_ready_out != 2'b00) a_ready_cycles++;
        if (ifa.req_ready_out == 2'b11 || ifb.req_ready_out == 2'b11) viol++;
        if ((ifa.req_ready_out != 2'b00 && ifa.busy_out) || (ifb.req_ready_out != 2'b00 && ifb.busy_out)) viol++;
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit sel_b, input int n);
        int k;
        k = 0;
        while (((sel_b ? qb_g.size() : qa_g.size()) < n) && k < 300) begin
            cycles(1);
            k++;
        end
        chk(sel_b ? "b_grant_wait" : "a_grant_wait", 32'((sel_b ? qb_g.size() : qa_g.size()) >= n), 32'd1);
    endtask

    function automatic logic [7:0] a_byte(input int i);
        return (i < qa_b.size()) ? qa_b[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] b_byte(input int i);
        return (i < qb_b.size()) ? qb_b[i] : 8'hxx;
    endfunction

    function automatic int a_bc(input int i);
        return (i < qa_bc.size()) ? qa_bc[i] : -1000;
    endfunction

    function automatic int a_gc(input int i);
        return (i < qa_gc.size()) ? qa_gc[i] : -1000;
    endfunction

    task automatic clear_q();
        qa_b.delete(); qa_bc.delete(); qa_g.delete(); qa_gc.delete();
        qb_b.delete(); qb_bc.delete(); qb_g.delete(); qb_gc.delete();
    endtask

    logic [7:0]  exp_t2 [9] = '{8'h01, 8'h40, 8'h80, 8'h3F, 8'h7F, 8'h9F, 8'h01, 8'h40, 8'h80};
    logic [16:0] sent_t2 [3] = '{17'h00001, 17'h1FFFF, 17'h00001};
    logic [16:0] rx_word;

    initial begin
        ifa.req_valid_in = 2'b00; ifa.req0_data_in = '0; ifa.req1_data_in = '0; ifa.tx_ready_in = 1'b1;
        ifb.req_valid_in = 2'b00; ifb.req0_data_in = '0; ifb.req1_data_in = '0; ifb.tx_ready_in = 1'b1;

        #23;
        chk("rst_ready", 32'(ifa.req_ready_out), 32'd0);
        chk("rst_tx_valid", 32'(ifa.tx_valid_out), 32'd0);
        chk("rst_tx_byte", 32'(ifa.tx_byte_out), 32'd0);
        chk("rst_grant_id", 32'(ifa.grant_id_out), 32'd0);
        chk("rst_busy", 32'(ifa.busy_out | ifb.busy_out), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        cycles(2);

        // Single word from requester 0
        clear_q(); a_ready_cycles = 0;
        ifa.req0_data_in = 17'h1ABCD; ifa.req_valid_in = 2'b01;
        #1 chk("t1_ready_comb", 32'(ifa.req_ready_out), 32'h1);
        wait_gnt(1'b0, 1);
        ifa.req_valid_in = 2'b00;
        chk("t1_grant_id", 32'(ifa.grant_id_out), 32'd0);
        chk("t1_busy", 32'(ifa.busy_out), 32'd1);
        cycles(12);
        chk("t1_nbytes", 32'(qa_b.size()), 32'd3);
        chk("t1_b1", 32'(a_byte(0)), 32'h0D);
        chk("t1_b2", 32'(a_byte(1)), 32'h6F);
        chk("t1_b3", 32'(a_byte(2)), 32'h9A);
        chk("t1_b1_lat", 32'(a_bc(0) - a_gc(0)), 32'd1);
        chk("t1_consec", 32'(a_bc(2) - a_bc(0)), 32'd2);
        chk("t1_ready_cycles", 32'(a_ready_cycles), 32'd1);
        chk("t1_idle_busy", 32'(ifa.busy_out), 32'd0);

        // Contention after reset: req0 first, then alternate
        #2 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        clear_q();
        ifa.req0_data_in = 17'h00001; ifa.req1_data_in = 17'h1FFFF; ifa.req_valid_in = 2'b11;
        wait_gnt(1'b0, 3);
        ifa.req_valid_in = 2'b00;
        cycles(20);
        chk("t2_ngrants", 32'(qa_g.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk($sformatf("t2_gnt%0d", i), 32'((i < qa_g.size()) ? qa_g[i] : 1'bx), 32'(i % 2));
        chk("t2_nbytes", 32'(qa_b.size()), 32'd9);
        for (int i = 0; i < 9; i++) chk($sformatf("t2_byte%0d", i), 32'(a_byte(i)), 32'(exp_t2[i]));
        for (int w = 0; w < 3; w++) begin
            rx_word = {a_byte(3*w+2)[4:0], a_byte(3*w+1)[5:0], a_byte(3*w)[5:0]};
            chk($sformatf("t2_rx_word%0d", w), 32'(rx_word), 32'(sent_t2[w]));
        end
        chk("t2_gap0", 32'(a_gc(1) - a_bc(2)), 32'd5);
        chk("t2_gap1", 32'(a_gc(2) - a_bc(5)), 32'd5);
        chk("t2_throughput", 32'(a_gc(1) - a_gc(0)), 32'd8);

        // Back-pressure during SEND_B2
        clear_q();
        ifa.req0_data_in = 17'h12345; ifa.req_valid_in = 2'b01;
        wait_gnt(1'b0, 1);
        ifa.req_valid_in = 2'b00;
        cycles(1);
        ifa.tx_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_hold_byte%0d", i), 32'(ifa.tx_byte_out), 32'h4D);
            chk($sformatf("t3_hold_valid%0d", i), 32'(ifa.tx_valid_out), 32'd1);
            cycles(1);
        end
        ifa.tx_ready_in = 1'b1;
        cycles(10);
        chk("t3_nbytes", 32'(qa_b.size()), 32'd3);
        chk("t3_b1", 32'(a_byte(0)), 32'h05);
        chk("t3_b2", 32'(a_byte(1)), 32'h4D);
        chk("t3_b3", 32'(a_byte(2)), 32'h92);

        // Zero gap: next grant in the cycle after B3
        clear_q();
        ifb.req0_data_in = 17'h0F0F0; ifb.req_valid_in = 2'b01;
        wait_gnt(1'b1, 2);
        ifb.req_valid_in = 2'b00;
        cycles(8);
        chk("t4_nbytes", 32'(qb_b.size()), 32'd6);
        chk("t4_b1", 32'(b_byte(0)), 32'h30);
        chk("t4_b2", 32'(b_byte(1)), 32'h43);
        chk("t4_b3", 32'(b_byte(2)), 32'h8F);
        chk("t4_nogap", 32'(((qb_gc.size() > 1) ? qb_gc[1] : -1000) - ((qb_bc.size() > 2) ? qb_bc[2] : 0)), 32'd1);

        // Asynchronous reset between B1 and B2
        clear_q();
        ifb.req1_data_in = 17'h15555; ifb.req_valid_in = 2'b10;
        wait_gnt(1'b1, 1);
        chk("t5_grant_id", 32'(ifb.grant_id_out), 32'd1);
        cycles(1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(ifb.req_ready_out), 32'd0);
        chk("t5_rst_valid", 32'(ifb.tx_valid_out), 32'd0);
        chk("t5_rst_byte", 32'(ifb.tx_byte_out), 32'd0);
        chk("t5_rst_grant", 32'(ifb.grant_id_out), 32'd0);
        chk("t5_rst_busy", 32'(ifb.busy_out), 32'd0);
        ifb.req1_data_in = 17'h0AAAA;
        cycles(3);
        chk("t5_abandon", 32'(qb_b.size()), 32'd1);
        chk("t5_first_b1", 32'(b_byte(0)), 32'h15);
        rst_n = 1'b1;
        wait_gnt(1'b1, 2);
        ifb.req_valid_in = 2'b00;
        cycles(6);
        chk("t5_nbytes", 32'(qb_b.size()), 32'd4);
        chk("t5_regrant", 32'((qb_g.size() > 1) ? qb_g[1] : 1'bx), 32'd1);
        chk("t5_b1", 32'(b_byte(1)), 32'h2A);
        chk("t5_b2", 32'(b_byte(2)), 32'h6A);
        chk("t5_b3", 32'(b_byte(3)), 32'h8A);

        chk("ready_onehot_idle_only", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16, idle clock cycles inserted after each 3-byte word (0 = no gap).
REQ-002 SHALL have port clk_in, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid_in, input, 2, per-requester word-valid; bit i belongs to requester i.
REQ-005 SHALL have port req0_data_in, input, 17, word of requester 0.
REQ-006 SHALL have port req1_data_in, input, 17, word of requester 1.
REQ-007 SHALL have port req_ready_out, output, 2, one-hot accept; word i is transferred when req_valid_in[i] && req_ready_out[i].
REQ-008 SHALL have port tx_byte_out, output, 8, byte presented to the byte transmitter.
REQ-009 SHALL have port tx_valid_out, output, 1, tx_byte_out is valid.
REQ-010 SHALL have port tx_ready_in, input, 1, transmitter can accept a byte; a byte is transferred on the cycle where tx_valid_out && tx_ready_in.
REQ-011 SHALL have port grant_id_out, output, 1, index of the requester whose word is in flight.
REQ-012 SHALL have port busy_out, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement the states IDLE, SEND_B1, SEND_B2, SEND_B3 and GAP.
REQ-014 In IDLE with any req_valid_in bit set, SHALL grant by round-robin: the requester other than last_grant wins on contention, and a sole requester wins outright.
REQ-015 The grant SHALL be combinational in IDLE: req_ready_out[g] = 1 in that same cycle, the word is latched into a 17-bit register, last_grant and grant_id_out are set to g, and the state becomes SEND_B1.
REQ-016 req_ready_out SHALL be 0 in every state other than IDLE, and SHALL never be 0b11.
REQ-017 Byte framing: SEND_B1 SHALL present {2'b00, w[5:0]}, SEND_B2 SHALL present {2'b01, w[11:6]}, and SEND_B3 SHALL present {3'b100, w[16:12]}.
REQ-018 tx_valid_out SHALL be 1 only in the SEND_B1, SEND_B2 and SEND_B3 states.
REQ-019 On each byte transfer the state SHALL advance from B1 to B2 and from B2 to B3; a transfer in B3 SHALL advance to GAP when GAP_CYCLES > 0, and to IDLE otherwise.
REQ-020 While tx_ready_in = 0, tx_byte_out and tx_valid_out SHALL hold stable, and the state SHALL not change.
REQ-021 Each word SHALL produce exactly 3 transfers, in order B1, B2, B3, with no byte from another word interleaved.
REQ-022 GAP SHALL load a counter with GAP_CYCLES-1 on entry, decrement it each cycle, and exit to IDLE in the cycle after the counter reads 0, giving exactly GAP_CYCLES cycles.
REQ-023 Best-case word throughput SHALL be 1 (IDLE) + 3 + GAP_CYCLES cycles.
REQ-024 Changes to req_valid_in or data while a word is in flight SHALL not affect the latched word.
REQ-025 A requester that drops valid before it is granted SHALL lose nothing, because no transfer took place.

Reset
REQ-026 rst_n_in = 0 SHALL immediately (asynchronously) force: state IDLE, req_ready_out 0, tx_valid_out 0, tx_byte_out 0x00, grant_id_out 0, busy_out 0, gap counter 0, word register 0, last_grant 1 (so requester 0 wins the first contention).
REQ-027 Reset asserted mid-word SHALL abandon the word with no further bytes sent; after release, operation SHALL resume from IDLE on the next rising edge.

Verification
REQ-028 Single word: req0 = 0x1ABCD, tx_ready_in = 1 -> bytes 0x0D, 0x6F, 0x9A in consecutive cycles; req_ready_out = 0b01 for one cycle; grant_id_out = 0.
REQ-029 Contention: both valid continuously, req0 = 0x00001, req1 = 0x1FFFF -> words alternate req0, req1, req0; byte sequences 0x01,0x40,0x80 and 0x3F,0x7F,0x9F.
REQ-030 Back-pressure: tx_ready_in low for 5 cycles during SEND_B2 -> the B2 byte is held stable for those 5 cycles; no duplicate or dropped byte.
REQ-031 Gap: GAP_CYCLES = 4 with req0 always valid -> exactly 4 cycles with tx_valid_out = 0 and busy_out = 1 between B3 of one word and the next grant. GAP_CYCLES = 0 -> the next grant comes in the cycle after B3.
REQ-032 Reset mid-word: rst_n_in low between B1 and B2 -> outputs take REQ-026 values without a clock edge; after release, a new req1 word is framed from B1.
REQ-033 Round-trip: feed the byte stream into the existing 17-bit UART receive path -> the received data_out equals the sent words, in the same order.
